// File: rtl/reg_file_wb.sv
// Write-back register file: two combinational read ports, one 32-bit write port.
// A 64-bit product write (MD=3) is split over two edges, with busy raised for the upper word.
module reg_file_wb #(
    parameter int unsigned WORD   = 32,
    parameter int unsigned AW     = 5,
    parameter bit          BYPASS = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                RW,
    input  logic [1:0]          MD,
    input  logic [AW-1:0]       DA,
    input  logic [AW-1:0]       AA,
    input  logic [AW-1:0]       BA,
    input  logic [2*WORD-1:0]   Bus_D,
    output logic [WORD-1:0]     A_data,
    output logic [WORD-1:0]     B_data,
    output logic                busy
);

    localparam int unsigned NREG = 2 ** AW;

    typedef enum logic {StIdle, StHi} state_e;

    state_e          state;
    logic [WORD-1:0] regs [NREG];
    logic [WORD-1:0] hi_word;
    logic [AW-1:0]   hi_addr;

    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [WORD-1:0] wr_data;

    // The single physical write port; address 0 is never written so R0 stays zero.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = DA;
        wr_data = Bus_D[WORD-1:0];
        if (state == StHi) begin
            wr_en   = (hi_addr != '0);
            wr_addr = hi_addr;
            wr_data = hi_word;
        end else begin
            wr_en   = RW && (DA != '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= StIdle;
            hi_word <= '0;
            hi_addr <= '0;
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                regs[wr_addr] <= wr_data;
            end
            case (state)
                StIdle: begin
                    if (RW && (MD == 2'd3)) begin
                        hi_word <= Bus_D[2*WORD-1:WORD];
                        hi_addr <= DA + AW'(1);
                        state   <= StHi;
                    end
                end
                StHi: begin
                    // Inputs are held upstream during this cycle and are not re-executed.
                    state <= StIdle;
                end
            endcase
        end
    end

    assign busy   = (state == StHi);
    assign A_data = (BYPASS && wr_en && (AA == wr_addr)) ? wr_data : regs[AA];
    assign B_data = (BYPASS && wr_en && (BA == wr_addr)) ? wr_data : regs[BA];

endmodule

// File: tb/tb_reg_file_wb.sv
// Bench for reg_file_wb: drives a bypassing and a non-bypassing instance in lockstep
// and checks both against an architectural model of the register file.
module tb_reg_file_wb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        RW;
    logic [1:0]  MD;
    logic [4:0]  DA, AA, BA;
    logic [63:0] Bus_D;
    logic [31:0] a1, b1, a0, b0;
    logic        busy1, busy0;

    int n_cmp = 0;
    int n_err = 0;

    // Architectural model: register contents plus at most one pending upper word.
    logic [31:0] model [32];
    bit          m_hi;
    logic [4:0]  m_hi_addr;
    logic [31:0] m_hi_word;

    always #5 clk = ~clk;

    reg_file_wb #(.WORD(32), .AW(5), .BYPASS(1'b1)) u_byp (
        .clk(clk), .rst_n(rst_n), .RW(RW), .MD(MD), .DA(DA), .AA(AA), .BA(BA),
        .Bus_D(Bus_D), .A_data(a1), .B_data(b1), .busy(busy1)
    );

    reg_file_wb #(.WORD(32), .AW(5), .BYPASS(1'b0)) u_nob (
        .clk(clk), .rst_n(rst_n), .RW(RW), .MD(MD), .DA(DA), .AA(AA), .BA(BA),
        .Bus_D(Bus_D), .A_data(a0), .B_data(b0), .busy(busy0)
    );

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        m_hi = 1'b0;
    endfunction

    function automatic void model_edge();
        if (m_hi) begin
            if (m_hi_addr != 5'd0) model[m_hi_addr] = m_hi_word;
            m_hi = 1'b0;
        end else if (RW) begin
            if (DA != 5'd0) model[DA] = Bus_D[31:0];
            if (MD == 2'd3) begin
                m_hi      = 1'b1;
                m_hi_addr = 5'(DA + 5'd1);
                m_hi_word = Bus_D[63:32];
            end
        end
    endfunction

    // Value a read port should show right now, with or without forwarding.
    function automatic logic [31:0] model_read(input logic [4:0] addr, input bit byp);
        if (byp && addr != 5'd0) begin
            if (m_hi && addr == m_hi_addr) return m_hi_word;
            if (!m_hi && RW && addr == DA) return Bus_D[31:0];
        end
        return model[addr];
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        #3;
        rst_n = 1'b0;
        model_reset();
        for (int i = 0; i < 32; i++) begin
            AA = 5'(i);
            BA = 5'(31 - i);
            #0.1;
            n_cmp++;
            if ({a1, b1, a0, b0} !== 128'h0) begin
                n_err++;
                $display("FAIL reset_read[%0d]: got a1=%h b1=%h a0=%h b0=%h, want all 0",
                         i, a1, b1, a0, b0);
            end
        end
        n_cmp++;
        if (busy1 !== 1'b0 || busy0 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_busy: got %b/%b, want 0/0", busy1, busy0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_write();
        RW = 1'b1; MD = 2'd0; DA = 5'd5; Bus_D = 64'h00000000_DEADBEEF;
        step();
        RW = 1'b0; AA = 5'd5; BA = 5'd0;
        #1;
        n_cmp++;
        if (a1 !== 32'hDEADBEEF || a0 !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL single_r5: got %h/%h, want deadbeef", a1, a0);
        end
        n_cmp++;
        if (busy1 !== 1'b0 || busy0 !== 1'b0) begin
            n_err++;
            $display("FAIL single_busy: got %b/%b, want 0", busy1, busy0);
        end
        RW = 1'b1; DA = 5'd0; Bus_D = 64'hFFFFFFFF_FFFFFFFF;
        AA = 5'd0;
        #1;
        n_cmp++;
        if (a1 !== 32'h0 || a0 !== 32'h0) begin
            n_err++;
            $display("FAIL r0_bypass: got %h/%h, want 0", a1, a0);
        end
        step();
        RW = 1'b0;
        #1;
        n_cmp++;
        if (a1 !== 32'h0 || a0 !== 32'h0) begin
            n_err++;
            $display("FAIL r0_write: got %h/%h, want 0", a1, a0);
        end
    endtask

    task automatic test_product();
        logic [31:0] r9_before;
        r9_before = model[9];
        RW = 1'b1; MD = 2'd3; DA = 5'd6; Bus_D = 64'h12345678_9ABCDEF0;
        step();
        // A fresh write offered during HI must be ignored.
        MD = 2'd0; DA = 5'd9; Bus_D = 64'h0_11111111;
        AA = 5'd6; BA = 5'd7;
        #1;
        n_cmp++;
        if (busy1 !== 1'b1 || busy0 !== 1'b1) begin
            n_err++;
            $display("FAIL prod_busy_hi: got %b/%b, want 1", busy1, busy0);
        end
        n_cmp++;
        if (a1 !== 32'h9ABCDEF0 || a0 !== 32'h9ABCDEF0) begin
            n_err++;
            $display("FAIL prod_lo: got %h/%h, want 9abcdef0", a1, a0);
        end
        n_cmp++;
        if (b1 !== 32'h12345678 || b0 !== model[7]) begin
            n_err++;
            $display("FAIL prod_hi_fwd: got %h/%h, want 12345678/%h", b1, b0, model[7]);
        end
        step();
        RW = 1'b0;
        AA = 5'd9;
        #1;
        n_cmp++;
        if (busy1 !== 1'b0 || busy0 !== 1'b0) begin
            n_err++;
            $display("FAIL prod_busy_lo: got %b/%b, want 0", busy1, busy0);
        end
        n_cmp++;
        if (b1 !== 32'h12345678 || b0 !== 32'h12345678) begin
            n_err++;
            $display("FAIL prod_hi: got %h/%h, want 12345678", b1, b0);
        end
        n_cmp++;
        if (a1 !== r9_before || a0 !== r9_before) begin
            n_err++;
            $display("FAIL prod_r9_held: got %h/%h, want %h", a1, a0, r9_before);
        end
    endtask

    task automatic test_wrap();
        int busy_cycles = 0;
        RW = 1'b1; MD = 2'd3; DA = 5'd31; Bus_D = 64'hAAAAAAAA_55555555;
        step();
        RW = 1'b0;
        AA = 5'd31; BA = 5'd0;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (busy1 === 1'b1) busy_cycles++;
            n_cmp++;
            if (b1 !== 32'h0 || b0 !== 32'h0) begin
                n_err++;
                $display("FAIL wrap_r0[%0d]: got %h/%h, want 0", c, b1, b0);
            end
            step();
        end
        n_cmp++;
        if (busy_cycles != 1) begin
            n_err++;
            $display("FAIL wrap_busy_len: got %0d cycles, want 1", busy_cycles);
        end
        n_cmp++;
        if (a1 !== 32'h55555555 || a0 !== 32'h55555555) begin
            n_err++;
            $display("FAIL wrap_r31: got %h/%h, want 55555555", a1, a0);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] hw;
        RW = 1'b1; MD = 2'd0; DA = 5'd3; Bus_D = 64'h0_01020304;
        step();
        MD = 2'd1; Bus_D = 64'h0_CAFEF00D; AA = 5'd3;
        #1;
        n_cmp++;
        if (a1 !== 32'hCAFEF00D || a0 !== 32'h01020304) begin
            n_err++;
            $display("FAIL byp_idle: got %h/%h, want cafef00d/01020304", a1, a0);
        end
        step();
        RW = 1'b0;
        #1;
        n_cmp++;
        if (a1 !== 32'hCAFEF00D || a0 !== 32'hCAFEF00D) begin
            n_err++;
            $display("FAIL byp_after: got %h/%h, want cafef00d", a1, a0);
        end
        hw = $urandom;
        RW = 1'b1; MD = 2'd3; DA = 5'd12; Bus_D = {hw, 32'($urandom)};
        step();
        RW = 1'b0; AA = 5'd13;
        #1;
        n_cmp++;
        if (a1 !== hw || a0 !== model_read(5'd13, 1'b0)) begin
            n_err++;
            $display("FAIL byp_hi: got %h/%h, want %h/%h", a1, a0, hw, model_read(5'd13, 1'b0));
        end
        step();
    endtask

    task automatic test_reset_during_hi();
        RW = 1'b1; MD = 2'd3; DA = 5'd10; Bus_D = 64'h76543210_FEDCBA98;
        step();
        RW = 1'b0; AA = 5'd10; BA = 5'd11;
        #2;
        n_cmp++;
        if (busy1 !== 1'b1) begin
            n_err++;
            $display("FAIL rst_hi_pre: busy got %b, want 1", busy1);
        end
        rst_n = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if (busy1 !== 1'b0 || busy0 !== 1'b0) begin
            n_err++;
            $display("FAIL rst_hi_busy: got %b/%b, want 0", busy1, busy0);
        end
        n_cmp++;
        if ({a1, b1, a0, b0} !== 128'h0) begin
            n_err++;
            $display("FAIL rst_hi_regs: got %h %h %h %h, want 0", a1, b1, a0, b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        RW = 1'b1; MD = 2'd0; DA = 5'd4; Bus_D = 64'h0_0000BEEF;
        step();
        RW = 1'b0; AA = 5'd4;
        #1;
        n_cmp++;
        if (busy1 !== 1'b0 || a0 !== 32'h0000BEEF || b0 !== 32'h0) begin
            n_err++;
            $display("FAIL rst_hi_restart: busy=%b r4=%h r11=%h, want 0/0000beef/0", busy1, a0, b0);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 300; it++) begin
            RW    = ($urandom_range(0, 3) != 0);
            MD    = 2'($urandom_range(0, 3));
            DA    = ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom);
            Bus_D = {32'($urandom), 32'($urandom)};
            AA    = ($urandom_range(0, 2) == 0) ? DA : 5'($urandom);
            BA    = (m_hi && $urandom_range(0, 1) == 1) ? m_hi_addr : 5'($urandom);
            #1;
            n_cmp++;
            if (a1 !== model_read(AA, 1'b1) || b1 !== model_read(BA, 1'b1)) begin
                n_err++;
                $display("FAIL rand_byp[%0d]: got %h/%h, want %h/%h", it, a1, b1,
                         model_read(AA, 1'b1), model_read(BA, 1'b1));
            end
            n_cmp++;
            if (a0 !== model_read(AA, 1'b0) || b0 !== model_read(BA, 1'b0)) begin
                n_err++;
                $display("FAIL rand_nob[%0d]: got %h/%h, want %h/%h", it, a0, b0,
                         model_read(AA, 1'b0), model_read(BA, 1'b0));
            end
            n_cmp++;
            if (busy1 !== m_hi || busy0 !== m_hi) begin
                n_err++;
                $display("FAIL rand_busy[%0d]: got %b/%b, want %b", it, busy1, busy0, m_hi);
            end
            step();
        end
        RW = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1;
        RW = 1'b0; MD = 2'd0; DA = 5'd0; AA = 5'd0; BA = 5'd0; Bus_D = 64'h0;
        model_reset();
        test_reset();
        test_single_write();
        test_product();
        test_wrap();
        test_bypass();
        test_reset_during_hi();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
